// File: rtl/hps_pixel_server.sv
// Toggle-handshake responder serving SDRAM frame pixels (RD1/RD2 FIFOs) to the HPS over PIO.
// Define PIXSRV_TOP_EDGE_EN to build the top-edge tracker; otherwise oTOP_EDGE is tied to V_ACTIVE.
module hps_pixel_server #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int RD_LAT    = 1,
    parameter int PROBE_COL = 320
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iREQ,
    input  logic        iCLR,
    input  logic [9:0]  iTHRESH,
    input  logic [15:0] iRD_DATA1,
    input  logic [15:0] iRD_DATA2,
    output logic        oRD,
    output logic [15:0] oPIX_DATA1,
    output logic [15:0] oPIX_DATA2,
    output logic        oBINARY,
    output logic [9:0]  oX,
    output logic [8:0]  oY,
    output logic        oFRAME_DONE,
    output logic [8:0]  oTOP_EDGE,
    output logic        oBUSY,
    output logic        oACK
);

    // state  | meaning
    // IDLE   | waiting for a request toggle (req_s != oACK)
    // READ   | oRD strobe to both read FIFOs
    // WAIT   | RD_LAT cycles until FIFO data is valid, then capture
    // CALC   | average the RGB channels and threshold
    // RESP   | publish pixel, toggle oACK, advance raster counters
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CALC, S_RESP} state_t;

    localparam logic [9:0] X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_LAST   = 9'(V_ACTIVE - 1);
    localparam logic [8:0] Y_NONE   = 9'(V_ACTIVE);
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    state_t      state;
    logic        req_meta, req_s;
    logic [2:0]  lat_cnt;
    logic [15:0] d1_q, d2_q;
    logic        bin_q;
    logic [9:0]  x_cnt;
    logic [8:0]  y_cnt;

    logic        pending;
    logic        last_pix;
    logic [9:0]  r_val, g_val, b_val;
    logic [11:0] sum;
    logic [9:0]  avg;

    assign pending  = (req_s != oACK);
    assign last_pix = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    assign r_val = d2_q[9:0];
    assign g_val = {d1_q[14:10], d2_q[14:10]};
    assign b_val = d1_q[9:0];
    assign sum   = 12'(r_val) + 12'(g_val) + 12'(b_val);
    assign avg   = 10'(sum / 12'd3);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= S_IDLE;
            req_meta    <= 1'b0;
            req_s       <= 1'b0;
            lat_cnt     <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            bin_q       <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            oRD         <= 1'b0;
            oPIX_DATA1  <= '0;
            oPIX_DATA2  <= '0;
            oBINARY     <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oFRAME_DONE <= 1'b0;
            oBUSY       <= 1'b0;
            oACK        <= 1'b0;
        end else begin
            req_meta    <= iREQ;
            req_s       <= req_meta;
            oRD         <= 1'b0;
            oFRAME_DONE <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pending) begin
                        state <= S_READ;
                        oRD   <= 1'b1;
                        oBUSY <= 1'b1;
                    end
                end
                S_READ: begin
                    state   <= S_WAIT;
                    lat_cnt <= LAT_INIT;
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        d1_q  <= iRD_DATA1;
                        d2_q  <= iRD_DATA2;
                        state <= S_CALC;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                S_CALC: begin
                    bin_q <= (avg > iTHRESH);
                    state <= S_RESP;
                end
                S_RESP: begin
                    oPIX_DATA1  <= {1'b0, d1_q[14:0]};
                    oPIX_DATA2  <= {1'b0, d2_q[14:0]};
                    oBINARY     <= bin_q;
                    oX          <= x_cnt;
                    oY          <= y_cnt;
                    oACK        <= ~oACK;
                    oFRAME_DONE <= last_pix && !iCLR;
                    oBUSY       <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    oBUSY <= 1'b0;
                end
            endcase

            // A clear in the RESP cycle wins: the pixel is reported but not counted.
            if (iCLR) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (state == S_RESP) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? 9'd0 : y_cnt + 9'd1;
                end else begin
                    x_cnt <= x_cnt + 10'd1;
                end
            end
        end
    end

`ifdef PIXSRV_TOP_EDGE_EN
    localparam logic [9:0] PROBE = 10'(PROBE_COL);

    logic [8:0] edge_row;
    logic [8:0] edge_next;
    logic       probe_hit;

    // Only the first hit in the probe column of a frame is kept.
    assign probe_hit = (x_cnt == PROBE) && bin_q && (edge_row == Y_NONE);
    assign edge_next = probe_hit ? y_cnt : edge_row;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            edge_row  <= Y_NONE;
            oTOP_EDGE <= Y_NONE;
        end else if (iCLR) begin
            edge_row <= Y_NONE;
        end else if (state == S_RESP) begin
            if (last_pix) begin
                oTOP_EDGE <= edge_next;
                edge_row  <= Y_NONE;
            end else begin
                edge_row <= edge_next;
            end
        end
    end
`else
    assign oTOP_EDGE = Y_NONE;
`endif

endmodule
